// File: rtl/mmse_pkg.sv
// Shared definitions for the 2x2 MIMO MMSE detector blocks.
//   SAMPLE_W   : default sample width (two's-complement fixed point)
//   CD_TIMEOUT : default cd watchdog limit, in WAIT-state cycles
//   cd_state_t : cd_ctrl sequencer states
package mmse_pkg;

  localparam int SAMPLE_W   = 16;
  localparam int CD_TIMEOUT = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RUN0,
    ST_WAIT0,
    ST_RUN1,
    ST_WAIT1,
    ST_OUT
  } cd_state_t;

endpackage

// File: rtl/cd_watchdog.sv
// Cycle watchdog for one cd column.
//   clk, reset : clock, synchronous active-high reset
//   clear      : restart the count (asserted in the RUN cycle)
//   enable     : count this cycle (asserted while waiting on cd)
//   expired    : enable is high and TIMEOUT-1 cycles have already elapsed
module cd_watchdog #(
  parameter int TIMEOUT = mmse_pkg::CD_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt;

  // Count holds at LAST so it can never wrap back to an in-range value.
  always_ff @(posedge clk) begin
    if (reset || clear)            cnt <= '0;
    else if (enable && !expired)   cnt <= cnt + 1'b1;
  end

  assign expired = enable && (cnt == LAST);

endmodule

// File: rtl/cd_ctrl.sv
// Sequencer for the shared cd column-decomposition unit.
// Accepts one 2x2 channel matrix, runs column 0 then column 1 through cd,
// captures q1/q2/norm for each, and offers the result on a valid/ready port.
//   in_valid/in_ready, h11..h22        : matrix input (in_ready = state IDLE)
//   cd_start, cd_h1, cd_h2              : command to cd
//   cd_finish, cd_q1, cd_q2, cd_norm    : cd completion and results
//   out_valid/out_ready, q*, norm*, err : decomposition output
//   busy                                : transaction in progress
module cd_ctrl
  import mmse_pkg::*;
#(
  parameter int W       = SAMPLE_W,
  parameter int TIMEOUT = CD_TIMEOUT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] h11,
  input  logic [W-1:0] h21,
  input  logic [W-1:0] h12,
  input  logic [W-1:0] h22,
  output logic         cd_start,
  output logic [W-1:0] cd_h1,
  output logic [W-1:0] cd_h2,
  input  logic [W-1:0] cd_q1,
  input  logic [W-1:0] cd_q2,
  input  logic [W-1:0] cd_norm,
  input  logic         cd_finish,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] q11,
  output logic [W-1:0] q21,
  output logic [W-1:0] norm1,
  output logic [W-1:0] q12,
  output logic [W-1:0] q22,
  output logic [W-1:0] norm2,
  output logic         err,
  output logic         busy
);

  cd_state_t st, nxt;
  logic acc, cap0, cap1, abort0, abort1;
  logic wd_exp;
  logic [W-1:0] h12_r, h22_r;

  cd_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk     (clk),
    .reset   (reset),
    .clear   ((st == ST_RUN0) || (st == ST_RUN1)),
    .enable  ((st == ST_WAIT0) || (st == ST_WAIT1)),
    .expired (wd_exp)
  );

  always_ff @(posedge clk) begin
    if (reset) st <= ST_IDLE;
    else       st <= nxt;
  end

  // cd_finish wins over a same-cycle watchdog expiry.
  always_comb begin
    nxt    = st;
    acc    = 1'b0;
    cap0   = 1'b0;
    cap1   = 1'b0;
    abort0 = 1'b0;
    abort1 = 1'b0;
    case (st)
      ST_IDLE:  if (in_valid) begin nxt = ST_RUN0; acc = 1'b1; end
      ST_RUN0:  nxt = ST_WAIT0;
      ST_WAIT0: if (cd_finish)   begin nxt = ST_RUN1; cap0   = 1'b1; end
                else if (wd_exp) begin nxt = ST_OUT;  abort0 = 1'b1; end
      ST_RUN1:  nxt = ST_WAIT1;
      ST_WAIT1: if (cd_finish)   begin nxt = ST_OUT;  cap1   = 1'b1; end
                else if (wd_exp) begin nxt = ST_OUT;  abort1 = 1'b1; end
      ST_OUT:   if (out_ready) nxt = ST_IDLE;
      default:  nxt = ST_IDLE;
    endcase
  end

  assign in_ready = (st == ST_IDLE);

  // Outputs are decoded from the next state so they are registered yet line
  // up with the state they describe. Column-0 operands go straight to cd_h*
  // at accept; column-1 operands wait in h12_r/h22_r.
  always_ff @(posedge clk) begin
    if (reset) begin
      cd_start  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cd_h1     <= '0;
      cd_h2     <= '0;
      h12_r     <= '0;
      h22_r     <= '0;
      q11       <= '0;
      q21       <= '0;
      norm1     <= '0;
      q12       <= '0;
      q22       <= '0;
      norm2     <= '0;
    end else begin
      cd_start  <= (nxt == ST_RUN0) || (nxt == ST_RUN1);
      out_valid <= (nxt == ST_OUT);
      busy      <= (nxt != ST_IDLE);
      if (acc) begin
        cd_h1 <= h11;
        cd_h2 <= h21;
        h12_r <= h12;
        h22_r <= h22;
        err   <= 1'b0;
      end
      if (cap0) begin
        q11   <= cd_q1;
        q21   <= cd_q2;
        norm1 <= cd_norm;
        cd_h1 <= h12_r;
        cd_h2 <= h22_r;
      end
      if (cap1) begin
        q12   <= cd_q1;
        q22   <= cd_q2;
        norm2 <= cd_norm;
      end
      // A column-0 abort never runs column 1, so both columns read zero.
      if (abort0) begin
        q11   <= '0;
        q21   <= '0;
        norm1 <= '0;
        q12   <= '0;
        q22   <= '0;
        norm2 <= '0;
        err   <= 1'b1;
      end
      if (abort1) begin
        q12   <= '0;
        q22   <= '0;
        norm2 <= '0;
        err   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cd_ctrl.sv
module tb_cd_ctrl;
  localparam int W  = 16;
  localparam int T  = 8;
  localparam int NC = 4096;

  typedef struct packed {
    logic [W-1:0] q11, q21, n1, q12, q22, n2;
    logic         err;
  } res_t;

  logic clk = 1'b0;
  logic reset, in_valid, in_ready;
  logic [W-1:0] h11, h21, h12, h22;
  logic cd_start, cd_finish, out_valid, out_ready, err, busy;
  logic [W-1:0] cd_h1, cd_h2, cd_q1, cd_q2, cd_norm;
  logic [W-1:0] q11, q21, norm1, q12, q22, norm2;

  always #5 clk = ~clk;

  cd_ctrl #(.W(W), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .h11(h11), .h21(h21), .h12(h12), .h22(h22),
    .cd_start(cd_start), .cd_h1(cd_h1), .cd_h2(cd_h2),
    .cd_q1(cd_q1), .cd_q2(cd_q2), .cd_norm(cd_norm), .cd_finish(cd_finish),
    .out_valid(out_valid), .out_ready(out_ready),
    .q11(q11), .q21(q21), .norm1(norm1), .q12(q12), .q22(q22), .norm2(norm2),
    .err(err), .busy(busy)
  );

  // Per-cycle stimulus plan
  bit           d_rst[NC], d_inv[NC], d_fin[NC], d_ordy[NC];
  logic [W-1:0] d_h11[NC], d_h21[NC], d_h12[NC], d_h22[NC];
  logic [W-1:0] d_q1[NC], d_q2[NC], d_n[NC];
  // Per-cycle expectations
  bit           e_busy[NC], e_start[NC], e_hv[NC], e_ov[NC], e_zero[NC];
  logic [W-1:0] e_h1[NC], e_h2[NC];
  res_t         e_res[NC];

  int cyc = 0, last = 0, t_idle = 0;
  int n_chk = 0, n_pass = 0;
  int a_l3 = -100;

  // Stand-in cd arithmetic: any fixed function of the column operands.
  function automatic logic [3*W-1:0] resp(input logic [W-1:0] a, input logic [W-1:0] b);
    return {a ^ 16'h00FF, b + 16'h0001, a + b};
  endfunction

  // Transaction-level model: from accept cycle and cd latencies derive every
  // cycle's start/valid/busy and the final result word. l=0 or l>T: cd never
  // finishes that column. rst_off>0: reset asserted rst_off cycles after the
  // column-1 start, dropping the transaction.
  task automatic plan(input logic [W-1:0] a11, a21, a12, a22,
                      input int l0, l1, stall, req, rst_off, input bit spur,
                      output int acc, output int o);
    int a, s0, s1, e0, e1, h, lim;
    bit d0, d1;
    res_t r;
    logic [3*W-1:0] v0, v1;
    a = (req > t_idle) ? req : t_idle;
    for (int c = req; c <= a; c++) begin
      d_inv[c] = 1; d_h11[c] = a11; d_h21[c] = a21; d_h12[c] = a12; d_h22[c] = a22;
    end
    s0 = a + 1;
    d0 = (l0 >= 1 && l0 <= T);
    e0 = d0 ? s0 + l0 : s0 + T;
    s1 = 0; e1 = 0; d1 = 0;
    if (d0) begin
      s1 = e0 + 1;
      d1 = (l1 >= 1 && l1 <= T);
      e1 = d1 ? s1 + l1 : s1 + T;
    end
    o = d0 ? e1 + 1 : e0 + 1;
    h = o + stall;
    lim = (rst_off > 0) ? s1 + rst_off : NC - 1;
    v0 = resp(a11, a21);
    v1 = resp(a12, a22);
    r = '0;
    if (d0)       {r.q11, r.q21, r.n1} = v0;
    if (d0 && d1) {r.q12, r.q22, r.n2} = v1;
    r.err = !(d0 && d1);
    for (int c = a + 1; c <= h && c <= lim; c++) e_busy[c] = 1;
    e_start[s0] = 1;
    for (int c = s0; c <= e0 && c <= lim; c++) begin
      e_hv[c] = 1; e_h1[c] = a11; e_h2[c] = a21;
    end
    if (d0) begin
      if (s1 <= lim) e_start[s1] = 1;
      for (int c = s1; c <= e1 && c <= lim; c++) begin
        e_hv[c] = 1; e_h1[c] = a12; e_h2[c] = a22;
      end
      d_fin[e0] = 1;
      {d_q1[e0], d_q2[e0], d_n[e0]} = v0;
      if (d1 && e1 <= lim) begin
        d_fin[e1] = 1;
        {d_q1[e1], d_q2[e1], d_n[e1]} = v1;
      end
    end
    for (int c = o; c <= h && c <= lim; c++) begin
      e_ov[c] = 1; e_res[c] = r; d_ordy[c] = (c == h);
    end
    if (spur) begin
      d_fin[a] = 1; d_fin[s0] = 1;
      if (d0 && s1 <= lim) d_fin[s1] = 1;
      for (int c = o; c <= h && c <= lim; c++) d_fin[c] = 1;
    end
    if (rst_off > 0) begin
      d_rst[lim] = 1; e_zero[lim + 1] = 1; t_idle = lim + 1;
    end else t_idle = h + 1;
    acc = a;
  endtask

  task automatic apply(input int c);
    reset = d_rst[c]; in_valid = d_inv[c];
    h11 = d_h11[c]; h21 = d_h21[c]; h12 = d_h12[c]; h22 = d_h22[c];
    cd_finish = d_fin[c]; cd_q1 = d_q1[c]; cd_q2 = d_q2[c]; cd_norm = d_n[c];
    out_ready = d_ordy[c];
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    else n_pass++;
  endtask

  res_t act_res;
  assign act_res = {q11, q21, norm1, q12, q22, norm2, err};

  always @(negedge clk) begin
    if (cyc >= 1 && cyc <= last) begin
      chk("busy", busy, e_busy[cyc]);
      chk("in_ready", in_ready, !e_busy[cyc]);
      chk("cd_start", cd_start, e_start[cyc]);
      chk("out_valid", out_valid, e_ov[cyc]);
      if (e_hv[cyc]) chk("cd_h", {cd_h1, cd_h2}, {e_h1[cyc], e_h2[cyc]});
      if (e_ov[cyc]) chk("result", act_res, e_res[cyc]);
      if (e_zero[cyc]) begin
        chk("rst_cd_h", {cd_h1, cd_h2}, '0);
        chk("rst_result", act_res, '0);
      end
      // Hand-computed pins for the first (L=1) matrix accepted in cycle 4.
      if (cyc == 5) chk("lit_start0", {cd_start, cd_h1, cd_h2}, {1'b1, 16'hFE81, 16'h0181});
      if (cyc == 7) chk("lit_start1", {cd_start, cd_h1, cd_h2}, {1'b1, 16'h0100, 16'h0000});
      if (cyc == 9)
        chk("lit_out", {out_valid, q11, q21, norm1, q12, q22, norm2, err},
            {1'b1, 16'hFE7E, 16'h0182, 16'h0002, 16'h01FF, 16'h0001, 16'h0100, 1'b0});
      // L=3 after reset: out_valid first high at A+9.
      if (cyc == a_l3 + 8) chk("lit_l3_early", out_valid, 1'b0);
      if (cyc == a_l3 + 9) chk("lit_l3_ov", out_valid, 1'b1);
    end
  end

  function automatic logic [W-1:0] rw();
    return W'($urandom);
  endfunction

  initial begin
    int a, o;
    for (int c = 0; c < NC; c++) begin
      d_h11[c] = rw(); d_h21[c] = rw(); d_h12[c] = rw(); d_h22[c] = rw();
      d_q1[c] = rw(); d_q2[c] = rw(); d_n[c] = rw();
      d_ordy[c] = 1'($urandom_range(0, 1));
    end
    for (int c = 0; c <= 2; c++) d_rst[c] = 1;
    for (int c = 1; c <= 3; c++) e_zero[c] = 1;
    t_idle = 4;

    // normal, L=1
    plan(16'hFE81, 16'h0181, 16'h0100, 16'h0000, 1, 1, 0, 4, 0, 0, a, o);
    // backpressure 10 cycles; next matrix offered throughout the stall
    plan(rw(), rw(), rw(), rw(), 2, 3, 10, t_idle, 0, 0, a, o);
    plan(rw(), rw(), rw(), rw(), 1, 2, 0, o, 0, 0, a, o);
    // timeout in column 1, then in column 0
    plan(rw(), rw(), rw(), rw(), 2, 0, 0, t_idle, 0, 0, a, o);
    plan(rw(), rw(), rw(), rw(), 0, 0, 1, t_idle, 0, 1, a, o);
    // spurious finishes, and finish coincident with expiry in each column
    plan(rw(), rw(), rw(), rw(), 1, T, 1, t_idle + 1, 0, 1, a, o);
    plan(rw(), rw(), rw(), rw(), T, 1, 0, t_idle, 0, 1, a, o);
    // reset in WAIT1, then L=3
    plan(rw(), rw(), rw(), rw(), 2, 6, 0, t_idle, 2, 0, a, o);
    plan(rw(), rw(), rw(), rw(), 3, 3, 0, t_idle, 0, 0, a_l3, o);
    // back-to-back
    plan(rw(), rw(), rw(), rw(), 1, 1, 0, t_idle, 0, 0, a, o);
    plan(rw(), rw(), rw(), rw(), 2, 1, 0, a + 1, 0, 0, a, o);
    // random
    for (int i = 0; i < 60 && t_idle < NC - 60; i++)
      plan(rw(), rw(), rw(), rw(), $urandom_range(1, T + 1), $urandom_range(1, T + 1),
           $urandom_range(0, 3), t_idle + $urandom_range(0, 3), 0,
           1'($urandom_range(0, 1)), a, o);
    last = t_idle + 5;

    apply(0);
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      cyc = c;
      apply(c);
    end
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
